shifter_arbiter: RTL and testbench

// - Shares one combinational shifter (S/shift/B -> H) between two requesters.
// - Requester 0 is the ALU issue path; requester 1 is the load/store byte-alignment path.
// - Round-robin arbitration, valid/ready handshakes, one operation in flight.
// - The block drives the shifter inputs from registered operands and returns the captured result.

---
 rtl/shifter_arbiter_if.sv | 49 ++++
 rtl/shifter_arbiter.sv | 100 ++++++++++
 tb/tb_shifter_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shifter_arbiter_if.sv
// Bundles the two requester channels, the response channel and the external
// shifter connection of shifter_arbiter; the arbiter uses the slave side.
interface shifter_arbiter_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);
  logic               req0_valid;
  logic               req0_ready;
  logic [1:0]         req0_op;
  logic [SHAMT_W-1:0] req0_shamt;
  logic [DATA_W-1:0]  req0_data;

  logic               req1_valid;
  logic               req1_ready;
  logic [1:0]         req1_op;
  logic [SHAMT_W-1:0] req1_shamt;
  logic [DATA_W-1:0]  req1_data;

  logic               resp_valid;
  logic               resp_ready;
  logic [DATA_W-1:0]  resp_data;
  logic               resp_id;
  logic               resp_err;

  logic [1:0]         sh_S;
  logic [SHAMT_W-1:0] sh_shift;
  logic [DATA_W-1:0]  sh_B;
  logic [DATA_W-1:0]  sh_H;

  logic               busy;

  modport slave (
    input  req0_valid, req0_op, req0_shamt, req0_data,
    input  req1_valid, req1_op, req1_shamt, req1_data,
    input  resp_ready, sh_H,
    output req0_ready, req1_ready,
    output resp_valid, resp_data, resp_id, resp_err,
    output sh_S, sh_shift, sh_B, busy
  );

  modport master (
    output req0_valid, req0_op, req0_shamt, req0_data,
    output req1_valid, req1_op, req1_shamt, req1_data,
    output resp_ready, sh_H,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_data, resp_id, resp_err,
    input  sh_S, sh_shift, sh_B, busy
  );
endinterface

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one external combinational shifter between the
// ALU issue path (id 0) and the load/store alignment path (id 1).
module shifter_arbiter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  shifter_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [1:0] OP_ILLEGAL = 2'b01;

  state_t             state, state_nxt;
  logic               rr_last;
  logic               grant0, grant1;

  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [DATA_W-1:0]  data_q;
  logic               id_q;

  logic [DATA_W-1:0]  resp_data_q;
  logic               resp_id_q;
  logic               resp_err_q;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        // On a tie the requester that did not win last time goes first.
        grant0 = bus.req0_valid && (!bus.req1_valid || rr_last);
        grant1 = bus.req1_valid && (!bus.req0_valid || !rr_last);
        if (grant0 || grant1) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last     <= 1'b1;
      op_q        <= 2'b00;
      shamt_q     <= '0;
      data_q      <= '0;
      id_q        <= 1'b0;
      resp_data_q <= '0;
      resp_id_q   <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      if (grant0 || grant1) begin
        op_q    <= grant1 ? bus.req1_op    : bus.req0_op;
        shamt_q <= grant1 ? bus.req1_shamt : bus.req0_shamt;
        data_q  <= grant1 ? bus.req1_data  : bus.req0_data;
        id_q    <= grant1;
        rr_last <= grant1;
      end
      if (state == EXEC) begin
        resp_id_q <= id_q;
        // An illegal op never trusts the shifter output.
        if (op_q == OP_ILLEGAL) begin
          resp_data_q <= '0;
          resp_err_q  <= 1'b1;
        end else begin
          resp_data_q <= bus.sh_H;
          resp_err_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  assign bus.sh_S     = op_q;
  assign bus.sh_shift = shamt_q;
  assign bus.sh_B     = data_q;

  assign bus.resp_valid = (state == RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter with a behavioural shifter on sh_*.
module tb_shifter_arbiter;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  shifter_arbiter_if #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) bus ();

  shifter_arbiter #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference shifter; an unused encoding returns a marker so an illegal op
  // that leaks sh_H into the response is visible.
  always_comb begin
    case (bus.sh_S)
      2'b00:   bus.sh_H = bus.sh_B << bus.sh_shift;
      2'b10:   bus.sh_H = bus.sh_B >> bus.sh_shift;
      2'b11:   bus.sh_H = $unsigned($signed(bus.sh_B) >>> bus.sh_shift);
      default: bus.sh_H = 32'hDEAD_BEEF;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_shamt = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_shamt = '0; bus.req1_data = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    bus.resp_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data} !== 35'h0) begin
      n_bad++; $display("FAIL reset_resp got v=%b id=%b err=%b data=%h exp all 0",
                        bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data); end
    n_cmp++; if ({bus.sh_S, bus.sh_shift, bus.sh_B} !== 39'h0) begin
      n_bad++; $display("FAIL reset_sh got S=%b shift=%0d B=%h exp all 0", bus.sh_S, bus.sh_shift, bus.sh_B); end
    n_cmp++; if ({bus.busy, bus.req0_ready, bus.req1_ready} !== 3'b000) begin
      n_bad++; $display("FAIL reset_busy_ready got %b exp 000", {bus.busy, bus.req0_ready, bus.req1_ready}); end
  endtask

  // T1: single SLL, response two cycles after the handshake.
  task automatic test_sll();
    bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_shamt = 5'd4; bus.req0_data = 32'h0000_00F1;
    #1;
    n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_bad++; $display("FAIL t1_ready got %b exp 10", {bus.req0_ready, bus.req1_ready}); end
    step();
    bus.req0_valid = 1'b0;
    #1;
    n_cmp++; if ({bus.busy, bus.resp_valid, bus.sh_S, bus.sh_shift, bus.sh_B} !== {1'b1, 1'b0, 2'b00, 5'd4, 32'h0000_00F1}) begin
      n_bad++; $display("FAIL t1_exec got busy=%b v=%b S=%b shift=%0d B=%h exp 1 0 00 4 000000f1",
                        bus.busy, bus.resp_valid, bus.sh_S, bus.sh_shift, bus.sh_B); end
    step();
    n_cmp++; if ({bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data} !== {3'b100, 32'h0000_0F10}) begin
      n_bad++; $display("FAIL t1_resp got v=%b id=%b err=%b data=%h exp 1 0 0 00000f10",
                        bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data); end
    step();
    n_cmp++; if ({bus.resp_valid, bus.busy} !== 2'b00) begin
      n_bad++; $display("FAIL t1_release got v=%b busy=%b exp 0 0", bus.resp_valid, bus.busy); end
  endtask

  // T2: simultaneous requests right after reset; req0 is favoured first.
  task automatic test_rr_after_reset();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_op = 2'b11; bus.req0_shamt = 5'd1; bus.req0_data = 32'h8000_0000;
    bus.req1_valid = 1'b1; bus.req1_op = 2'b10; bus.req1_shamt = 5'd1; bus.req1_data = 32'h8000_0000;
    #1;
    n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_bad++; $display("FAIL t2_first_grant got %b exp 10", {bus.req0_ready, bus.req1_ready}); end
    step();
    bus.req0_valid = 1'b0;
    step();
    n_cmp++; if ({bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data} !== {3'b100, 32'hC000_0000}) begin
      n_bad++; $display("FAIL t2_resp0 got v=%b id=%b err=%b data=%h exp 1 0 0 c0000000",
                        bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data); end
    step();
    n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      n_bad++; $display("FAIL t2_second_grant got %b exp 01", {bus.req0_ready, bus.req1_ready}); end
    step();
    bus.req1_valid = 1'b0;
    step();
    n_cmp++; if ({bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data} !== {3'b110, 32'h4000_0000}) begin
      n_bad++; $display("FAIL t2_resp1 got v=%b id=%b err=%b data=%h exp 1 1 0 40000000",
                        bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data); end
    step();
  endtask

  // T3: both requesters saturate; grants alternate every third cycle.
  task automatic test_back_to_back();
    int grant_cyc[8];
    bit grant_id[8];
    int n_grant = 0;
    bus.resp_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_shamt = 5'd1; bus.req0_data = 32'h1;
    bus.req1_valid = 1'b1; bus.req1_op = 2'b10; bus.req1_shamt = 5'd1; bus.req1_data = 32'h2;
    #1;
    for (int i = 0; i < 12; i++) begin
      n_cmp++; if (bus.req0_ready && bus.req1_ready) begin
        n_bad++; $display("FAIL t3_double_grant cycle %0d got 11 exp at most one", i); end
      if ((bus.req0_ready || bus.req1_ready) && n_grant < 8) begin
        grant_cyc[n_grant] = i;
        grant_id[n_grant]  = bus.req1_ready;
        n_grant++;
      end
      if (i == 11) clear_reqs();
      step();
    end
    n_cmp++; if (n_grant !== 4) begin
      n_bad++; $display("FAIL t3_grant_count got %0d exp 4", n_grant); end
    for (int g = 0; g < 4 && g < n_grant; g++) begin
      n_cmp++; if (grant_id[g] !== g[0] || grant_cyc[g] !== 3 * g) begin
        n_bad++; $display("FAIL t3_grant%0d got id=%0d cycle=%0d exp id=%0d cycle=%0d",
                          g, grant_id[g], grant_cyc[g], g[0], 3 * g); end
    end
  endtask

  // T4: consumer stalls; response and readies must hold while stalled.
  task automatic test_stall();
    bus.resp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 2'b10; bus.req0_shamt = 5'd8; bus.req0_data = 32'h1234_5678;
    #1;
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op = 2'b00; bus.req1_shamt = 5'd2; bus.req1_data = 32'h3;
    step();
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if ({bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data, bus.req0_ready, bus.req1_ready}
                   !== {3'b100, 32'h0012_3456, 2'b00}) begin
        n_bad++; $display("FAIL t4_hold%0d got v=%b id=%b err=%b data=%h rdy=%b%b exp 1 0 0 00123456 00", k,
                          bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data, bus.req0_ready, bus.req1_ready); end
      step();
    end
    bus.req1_valid = 1'b0;
    bus.resp_ready = 1'b1;
    step();
    n_cmp++; if ({bus.resp_valid, bus.busy} !== 2'b00) begin
      n_bad++; $display("FAIL t4_release got v=%b busy=%b exp 0 0", bus.resp_valid, bus.busy); end
  endtask

  // T5: illegal op from req1 returns an error with zero data.
  task automatic test_illegal();
    bus.req1_valid = 1'b1; bus.req1_op = 2'b01; bus.req1_shamt = 5'd3; bus.req1_data = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      n_bad++; $display("FAIL t5_grant got %b exp 01", {bus.req0_ready, bus.req1_ready}); end
    step();
    bus.req1_valid = 1'b0;
    step();
    n_cmp++; if ({bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data} !== {3'b111, 32'h0}) begin
      n_bad++; $display("FAIL t5_resp got v=%b id=%b err=%b data=%h exp 1 1 1 00000000",
                        bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data); end
    step();
  endtask

  // A zero shift amount leaves the operand untouched for every legal op.
  task automatic test_passthrough();
    logic [1:0] ops [3] = '{2'b00, 2'b10, 2'b11};
    for (int j = 0; j < 3; j++) begin
      bus.req0_valid = 1'b1; bus.req0_op = ops[j]; bus.req0_shamt = 5'd0; bus.req0_data = 32'h8000_0001;
      #1;
      step();
      bus.req0_valid = 1'b0;
      step();
      n_cmp++; if ({bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data} !== {3'b100, 32'h8000_0001}) begin
        n_bad++; $display("FAIL pass_op%b got v=%b id=%b err=%b data=%h exp 1 0 0 80000001", ops[j],
                          bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data); end
      step();
    end
  endtask

  // T6: reset during EXEC drops the op and restores req0 priority.
  task automatic test_reset_mid_op();
    bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_shamt = 5'd1; bus.req0_data = 32'h5;
    #1;
    step();
    bus.req0_valid = 1'b0;
    #1;
    n_cmp++; if ({bus.busy, bus.sh_B} !== {1'b1, 32'h5}) begin
      n_bad++; $display("FAIL t6_exec got busy=%b B=%h exp 1 00000005", bus.busy, bus.sh_B); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus.busy, bus.resp_valid, bus.sh_S, bus.sh_shift, bus.sh_B} !== 41'h0) begin
      n_bad++; $display("FAIL t6_async got busy=%b v=%b S=%b shift=%0d B=%h exp all 0",
                        bus.busy, bus.resp_valid, bus.sh_S, bus.sh_shift, bus.sh_B); end
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (bus.resp_valid !== 1'b0) begin
        n_bad++; $display("FAIL t6_no_resp%0d got v=%b exp 0", k, bus.resp_valid); end
    end
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_bad++; $display("FAIL t6_regrant got %b exp 10", {bus.req0_ready, bus.req1_ready}); end
    clear_reqs();
    step();
  endtask

  initial begin
    clear_reqs();
    bus.resp_ready = 1'b1;
    test_reset();
    test_sll();
    test_rr_after_reset();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_passthrough();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "bench did not complete");
  end

endmodule
